// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: decode read/issue port and writeback port.
// The master side (decode + writeback) drives addresses, issue and write
// controls; the slave side (the register file) returns read data, busy
// flags and the pending-write count.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic [AW-1:0]   A1;
    logic [AW-1:0]   A2;
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;
    logic            busy1;
    logic            busy2;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            WE;
    logic [AW-1:0]   A3;
    logic [XLEN-1:0] WD3;
    logic [AW:0]     pending_cnt;

    modport master (
        output A1, A2, issue_valid, issue_rd, WE, A3, WD3,
        input  RD1, RD2, busy1, busy2, pending_cnt
    );

    modport slave (
        input  A1, A2, issue_valid, issue_rd, WE, A3, WD3,
        output RD1, RD2, busy1, busy2, pending_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: XLEN x NREG integer register file with two combinational read
// ports, one synchronous write port and a per-register pending-write
// scoreboard used by decode for RAW hazard detection. Register 0 reads as
// zero and can never be marked busy.
// Optional build macro REGFILE_BYPASS_EN: same-cycle write-through
// forwarding from the write port to both read ports (outputs only).
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_cnt;

    logic            w_set;
    logic            w_clr;
    logic            w_inc;
    logic            w_dec;
    logic [NREG-1:0] w_busy_nxt;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic            w_busy1;
    logic            w_busy2;

    // Scoreboard next state: clear from writeback first, then set from issue so
    // a new producer supersedes the retiring one on the same register.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_set      = bus.issue_valid && (bus.issue_rd != '0);
        w_clr      = bus.WE && (bus.A3 != '0);
        w_busy_nxt = r_busy;
        if (w_clr) w_busy_nxt[bus.A3] = 1'b0;
        if (w_set) w_busy_nxt[bus.issue_rd] = 1'b1;
        w_inc      = w_set && !r_busy[bus.issue_rd];
        w_dec      = w_clr && r_busy[bus.A3] && !(w_set && (bus.issue_rd == bus.A3));
    end

    // Register array: cleared asynchronously, written on the rising edge.
    // NOTE: the array is reset because the clear is architecturally visible; a plain
    // storage memory without that requirement would be left unreset so it maps to RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_clr) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            r_regs[bus.A3] <= bus.WD3;
        end
    end

    // Busy bits and their population count, kept in step incrementally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= r_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
        end
    end

    // Read ports: stored state, address 0 forced to zero, optional forwarding.
    always_comb begin
        w_rd1   = (bus.A1 == '0) ? '0 : r_regs[bus.A1];
        w_rd2   = (bus.A2 == '0) ? '0 : r_regs[bus.A2];
        w_busy1 = r_busy[bus.A1];
        w_busy2 = r_busy[bus.A2];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is suppressed during reset so outputs reflect the cleared state.
        if (rst_n && w_clr && (bus.A1 == bus.A3)) begin
            w_rd1   = bus.WD3;
            w_busy1 = 1'b0;
        end
        if (rst_n && w_clr && (bus.A2 == bus.A3)) begin
            w_rd2   = bus.WD3;
            w_busy2 = 1'b0;
        end
`else
        // Without forwarding a read during a write returns the old value.
`endif
    end

    assign bus.RD1         = w_rd1;
    assign bus.RD2         = w_rd2;
    assign bus.busy1       = w_busy1;
    assign bus.busy2       = w_busy2;
    assign bus.pending_cnt = r_cnt;
endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: directed vector table, hand-written corner
// sequences, randomized traffic against a behavioural model, a 64x16
// parameter instance and an asynchronous mid-operation reset.
module tb_regfile_sb;
    localparam int XA = 32;
    localparam int NA = 32;
    localparam int XB = 64;
    localparam int NB = 16;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XA), .NREG(NA)) if_a ();
    regfile_sb_if #(.XLEN(XB), .NREG(NB)) if_b ();

    regfile_sb #(.XLEN(XA), .NREG(NA)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    regfile_sb #(.XLEN(XB), .NREG(NB)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model of the 32x32 instance: plain arrays of values and flags.
    logic [31:0] m_regs [NA];
    bit          m_busy [NA];

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        int          e_cnt;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NA; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    // Apply one clock edge's worth of architectural rules.
    function automatic void model_commit();
        if (if_a.WE && if_a.A3 != 0) begin
            m_regs[if_a.A3] = if_a.WD3;
            m_busy[if_a.A3] = 1'b0;
        end
        if (if_a.issue_valid && if_a.issue_rd != 0) m_busy[if_a.issue_rd] = 1'b1;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return '0;
        if (BYP && if_a.WE && if_a.A3 != 0 && a == if_a.A3) return if_a.WD3;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (BYP && if_a.WE && if_a.A3 != 0 && a == if_a.A3) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 0; i < NA; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic idle_a();
        if_a.WE = 1'b0; if_a.A3 = '0; if_a.WD3 = '0;
        if_a.issue_valid = 1'b0; if_a.issue_rd = '0;
    endtask

    task automatic idle_b();
        if_b.WE = 1'b0; if_b.A3 = '0; if_b.WD3 = '0;
        if_b.issue_valid = 1'b0; if_b.issue_rd = '0;
        if_b.A1 = '0; if_b.A2 = '0;
    endtask

    task automatic drive_a(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                           input logic iv, input logic [4:0] ird);
        if_a.WE = we; if_a.A3 = a3; if_a.WD3 = wd;
        if_a.issue_valid = iv; if_a.issue_rd = ird;
    endtask

    // One rising edge; the model commits on the same inputs the DUT samples.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_commit();
        #1;
    endtask

    task automatic check_a(input string tag);
        check($sformatf("%s rd1", tag),  64'(if_a.RD1),         64'(exp_rd(if_a.A1)));
        check($sformatf("%s rd2", tag),  64'(if_a.RD2),         64'(exp_rd(if_a.A2)));
        check($sformatf("%s b1", tag),   64'(if_a.busy1),       64'(exp_busy(if_a.A1)));
        check($sformatf("%s b2", tag),   64'(if_a.busy2),       64'(exp_busy(if_a.A2)));
        check($sformatf("%s cnt", tag),  64'(if_a.pending_cnt), 64'(exp_cnt()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           we    a3     wd            iv    ird    a1     a2     e_rd1         e_rd2         b1    b2    cnt
        tbl[0]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0,  5'd7,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 0};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  5'd7,  32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1};
        tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  5'd3,  5'd4,  32'h0,        32'h0,        1'b1, 1'b1, 2};
        tbl[4]  = '{1'b1, 5'd3,  32'h33,       1'b0, 5'd0,  5'd3,  5'd4,  32'h33,       32'h0,        1'b0, 1'b1, 1};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd4,  32'h0,        32'h0,        1'b1, 1'b1, 2};
        tbl[6]  = '{1'b1, 5'd9,  32'hAA,       1'b1, 5'd9,  5'd9,  5'd4,  32'hAA,       32'h0,        1'b1, 1'b1, 2};
        tbl[7]  = '{1'b1, 5'd9,  32'h99,       1'b1, 5'd10, 5'd9,  5'd10, 32'h99,       32'h0,        1'b0, 1'b1, 2};
        tbl[8]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  5'd10, 32'h0,        32'h0,        1'b0, 1'b1, 2};
        tbl[9]  = '{1'b1, 5'd7,  32'h77,       1'b0, 5'd0,  5'd7,  5'd3,  32'h77,       32'h33,       1'b0, 1'b0, 2};
        tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  5'd4,  5'd10, 32'h0,        32'h0,        1'b1, 1'b1, 2};
        tbl[11] = '{1'b1, 5'd4,  32'h44,       1'b0, 5'd0,  5'd4,  5'd10, 32'h44,       32'h0,        1'b0, 1'b1, 1};

        // Reset state, observed while rst_n is still low.
        idle_a(); idle_b();
        if_a.A1 = 5'd5; if_a.A2 = 5'd7;
        model_reset();
        #12;
        check("rst rd1", 64'(if_a.RD1), 64'h0);
        check("rst b1",  64'(if_a.busy1), 64'h0);
        check("rst cnt", 64'(if_a.pending_cnt), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vector table: one edge of stimulus, then a read-only look.
        foreach (tbl[i]) begin
            drive_a(tbl[i].we, tbl[i].a3, tbl[i].wd, tbl[i].iv, tbl[i].ird);
            step();
            idle_a();
            if_a.A1 = tbl[i].a1;
            if_a.A2 = tbl[i].a2;
            #1;
            check($sformatf("vec%0d rd1", i), 64'(if_a.RD1),         64'(tbl[i].e_rd1));
            check($sformatf("vec%0d rd2", i), 64'(if_a.RD2),         64'(tbl[i].e_rd2));
            check($sformatf("vec%0d b1", i),  64'(if_a.busy1),       64'(tbl[i].e_b1));
            check($sformatf("vec%0d b2", i),  64'(if_a.busy2),       64'(tbl[i].e_b2));
            check($sformatf("vec%0d cnt", i), 64'(if_a.pending_cnt), 64'(tbl[i].e_cnt));
        end

        // Read during write of reg 7, which is also busy.
        drive_a(1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 5'd7);
        step();
        drive_a(1'b1, 5'd7, 32'h00000001, 1'b0, 5'd0);
        if_a.A1 = 5'd7; if_a.A2 = 5'd10;
        #1;
        check("rdw rd1", 64'(if_a.RD1),   BYP ? 64'h1 : 64'hDEADBEEF);
        check("rdw b1",  64'(if_a.busy1), BYP ? 64'h0 : 64'h1);
        check_a("rdw");
        step();
        idle_a();
        #1;
        check("rdw post rd1", 64'(if_a.RD1), 64'h1);
        check("rdw post b1",  64'(if_a.busy1), 64'h0);
        check("rdw post cnt", 64'(if_a.pending_cnt), 64'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a3;
            a3 = 5'($urandom_range(0, 31));
            drive_a(1'($urandom_range(0, 1)), a3, $urandom(),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            if_a.A1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
            if_a.A2 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
            #1;
            check_a($sformatf("rnd%0d", n));
            step();
        end
        idle_a();

        // 64-bit x 16 instance: wide data and a full scoreboard.
        if_b.WE = 1'b1; if_b.A3 = 4'd15; if_b.WD3 = 64'h0123456789ABCDEF;
        step();
        if_b.WE = 1'b0; if_b.A1 = 4'd15;
        #1;
        check("w64 rd1", if_b.RD1, 64'h0123456789ABCDEF);
        for (int r = 1; r < NB; r++) begin
            if_b.issue_valid = 1'b1; if_b.issue_rd = 4'(r);
            step();
        end
        if_b.issue_valid = 1'b0; if_b.A2 = 4'd15;
        #1;
        check("w64 full cnt", 64'(if_b.pending_cnt), 64'd15);
        check("w64 full b2",  64'(if_b.busy2), 64'h1);
        if_b.WE = 1'b1; if_b.A3 = 4'd15; if_b.WD3 = '0;
        step();
        if_b.WE = 1'b0;
        #1;
        check("w64 ret cnt", 64'(if_b.pending_cnt), 64'd14);
        check("w64 ret b2",  64'(if_b.busy2), 64'h0);

        // Asynchronous reset in the middle of a cycle with traffic in flight.
        drive_a(1'b1, 5'd5, 32'h12345678, 1'b1, 5'd6);
        step();
        drive_a(1'b1, 5'd9, 32'hCAFE0000, 1'b1, 5'd8);
        if_a.A1 = 5'd5; if_a.A2 = 5'd6;
        #1;
        check("pre-rst rd1", 64'(if_a.RD1), 64'h12345678);
        check("pre-rst b2",  64'(if_a.busy2), 64'h1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async rd1", 64'(if_a.RD1), 64'h0);
        check("async b2",  64'(if_a.busy2), 64'h0);
        check("async cnt", 64'(if_a.pending_cnt), 64'h0);
        check("async cnt b", 64'(if_b.pending_cnt), 64'h0);
        @(posedge clk); #1;
        idle_a();
        rst_n = 1'b1;
        if_a.A1 = 5'd9; if_a.A2 = 5'd8;
        #1;
        check_a("post-rst");
        step();
        check_a("post-rst edge");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the pipeline's integer register file.
- Provides XLEN-bit registers, NREG deep, with two asynchronous read ports and one synchronous write port.
- Adds asynchronous clear and a per-register pending-write scoreboard. The decode stage uses the scoreboard to detect RAW hazards without a separate hazard table.
- Sits between decode (read, issue) and writeback (write, retire).

Parameters:
- XLEN, 32, register width in bits.
- NREG, 32, number of registers; power of two, minimum 2.
- AW, $clog2(NREG), address width; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- A1  input  AW  read port 1 address.
- A2  input  AW  read port 2 address.
- RD1  output  XLEN  read port 1 data; combinational.
- RD2  output  XLEN  read port 2 data; combinational.
- busy1  output  1  register A1 has a pending write; combinational.
- busy2  output  1  register A2 has a pending write; combinational.
- issue_valid  input  1  decode issues an instruction that will write issue_rd.
- issue_rd  input  AW  destination of the issued instruction.
- WE  input  1  writeback write enable.
- A3  input  AW  writeback destination address.
- WD3  input  XLEN  writeback data.
- pending_cnt  output  AW+1  number of registers currently marked busy.

Behaviour:
- Reset is asynchronous, active-low; one clock; no other reset source.
- While rst_n=0, all of the following are cleared:
  - every register,
  - every busy bit,
  - pending_cnt.
- Consequently RD1=RD2=0, busy1=busy2=0 and pending_cnt=0 during reset.
- Deassertion is sampled on the next rising edge.
- Register 0 is hardwired to zero:
  - writes to A3=0 are ignored;
  - reads of address 0 return 0;
  - busy[0] never sets;
  - issue_rd=0 is a no-op.
- Write: on a rising edge with WE=1 and A3!=0, reg[A3] <= WD3. Latency 1 cycle.
- Read: RD1=reg[A1] and RD2=reg[A2], combinational, zero latency.
- Read-during-write without the optional feature: the read returns the old value. The new value is visible from the cycle after the edge.
- Scoreboard, evaluated per edge:
  - issue_valid=1 and issue_rd!=0 sets busy[issue_rd].
  - WE=1 and A3!=0 clears busy[A3].
  - Same register set and cleared in the same cycle: set wins. The new producer supersedes the retiring one. The data write still occurs.
  - Set of an already-busy register: stays busy, no count change.
  - Clear of a non-busy register: no effect, no underflow.
- busy1=busy[A1] and busy2=busy[A2], combinational from current state; address 0 always reads 0.
- pending_cnt equals the population count of busy. Maintained incrementally:
  - +1 on a 0->1 transition;
  - -1 on a 1->0 transition;
  - net 0 when one register is set and a different one is cleared in the same cycle.
- Maximum pending_cnt is NREG-1; width AW+1 cannot overflow.
- Reset mid-operation: any in-flight set or clear in that cycle is discarded. All state returns to zero.
- No handshake back-pressure: every issue and write is accepted unconditionally.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding, in the same cycle.
  - If WE=1, A3!=0 and A1==A3, then RD1=WD3 and busy1=0.
  - The same applies to port 2.
  - Registered state is unchanged by this; forwarding only affects the outputs.
  - Address 0 still reads 0.
- Undefined: reads return stored state only. busy reflects stored bits only.
- Both builds must pass the common tests.

Test Plan:
- Reset: write 0x12345678 to reg 5, then assert rst_n=0 mid-cycle, asynchronously -> RD1 (A1=5) = 0 immediately, pending_cnt=0, before any clock edge.
- x0 protection: WE=1, A3=0, WD3=0xFFFFFFFF; issue_valid=1, issue_rd=0 -> RD1 (A1=0) = 0, busy1=0, pending_cnt=0.
- Basic write/read: write 0xDEADBEEF to reg 7 -> next cycle RD2 (A2=7) = 0xDEADBEEF.
- Same-cycle read of reg 7 while writing 0x1 to it:
  - without the macro, RD1=0xDEADBEEF;
  - with REGFILE_BYPASS_EN, RD1=0x00000001.
- Scoreboard:
  - issue rd=3, then rd=4 -> pending_cnt=2, busy1 (A1=3) = 1.
  - Next, writeback A3=3 -> busy1=0, pending_cnt=1.
- Set-wins collision: reg 9 busy; same cycle issue_rd=9 and WE=1, A3=9, WD3=0xAA -> next cycle busy[9]=1, reg 9=0xAA, pending_cnt unchanged.
  - Parallel case: set reg 10 while clearing reg 9 -> pending_cnt unchanged.
- Parameter sweep: XLEN=64, NREG=16 -> write 0x0123456789ABCDEF to reg 15 and read it back. Fill all 15 busy bits -> pending_cnt=15.
